// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for a ROWS x COLS weight-stationary bf16 systolic array.
// It loads the array weights one row at a time. It then streams m_len activation
// vectors from a sync-read buffer into the west edge, skewing lane r by r cycles.
// Idle lanes are gated to bf16 +0. It flags valid bottom-edge results per column
// and pulses done once the last column has drained.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, skip_wload   job request (sampled in IDLE), reuse resident weights
//   m_len               number of activation vectors (saturates to M_MAX)
//   busy, done          job in progress / one-cycle completion pulse
//   w_rd_en, w_rd_addr  weight buffer read port (one array row per read)
//   o_load              one-hot per-row PE weight load enable
//   a_rd_en, a_rd_addr  activation buffer read port
//   a_rd_data           activation read data, valid the cycle after a_rd_en
//   west_data           skewed activations, lane r = bits [16r+15:16r]
//   out_valid           bottom-edge result of column c is valid
module systolic_ctrl #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int M_MAX = 256,
    parameter int MW    = $clog2(M_MAX + 1),
    parameter int WAW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 skip_wload,
    input  logic [MW-1:0]        m_len,
    output logic                 busy,
    output logic                 done,
    output logic                 w_rd_en,
    output logic [WAW-1:0]       w_rd_addr,
    output logic [ROWS-1:0]      o_load,
    output logic                 a_rd_en,
    output logic [MW-1:0]        a_rd_addr,
    input  logic [ROWS*16-1:0]   a_rd_data,
    output logic [ROWS*16-1:0]   west_data,
    output logic [COLS-1:0]      out_valid
);

    localparam int NV = ROWS + COLS;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LOAD_TAIL, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [MW-1:0]     m_len_q;
    logic              ld_vld_p1;
    logic [WAW-1:0]    ld_row_p1;
    // vld_p[k] = a_rd_en delayed k+1 cycles; lanes use [0..ROWS-1], columns the rest.
    logic [NV-1:0]     vld_p;

    function automatic logic [MW-1:0] sat_len(input logic [MW-1:0] len);
        if (len > MW'(M_MAX)) return MW'(M_MAX);
        return len;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (!skip_wload)                state_nxt = S_LOAD_W;
                    else if (sat_len(m_len) != '0)  state_nxt = S_STREAM;
                    else                            state_nxt = S_DONE;
                end
            end
            S_LOAD_W:    if (w_rd_addr == WAW'(ROWS - 1)) state_nxt = S_LOAD_TAIL;
            S_LOAD_TAIL: state_nxt = (m_len_q != '0) ? S_STREAM : S_DONE;
            S_STREAM:    if (a_rd_addr == m_len_q - MW'(1)) state_nxt = S_DRAIN;
            // Last column's valid pulse is on its final cycle when the stage before it is empty.
            S_DRAIN:     if (vld_p[NV-1] && !vld_p[NV-2]) state_nxt = S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        w_rd_en = (state == S_LOAD_W);
        a_rd_en = (state == S_STREAM);
    end

    // Job length and read address counters; addresses rest at 0 outside their phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_len_q   <= '0;
            w_rd_addr <= '0;
            a_rd_addr <= '0;
            ld_vld_p1 <= 1'b0;
            ld_row_p1 <= '0;
            vld_p     <= '0;
        end else begin
            if (state == S_IDLE && start) m_len_q <= sat_len(m_len);
            w_rd_addr <= (w_rd_en && state_nxt == S_LOAD_W) ? w_rd_addr + WAW'(1) : '0;
            a_rd_addr <= (a_rd_en && state_nxt == S_STREAM) ? a_rd_addr + MW'(1) : '0;
            ld_vld_p1 <= w_rd_en;
            ld_row_p1 <= w_rd_addr;
            vld_p     <= {vld_p[NV-2:0], a_rd_en};
        end
    end

    // Weight row data arrives one cycle after its read, so the load strobe lags the address.
    always_comb begin
        o_load = '0;
        if (ld_vld_p1) o_load[ld_row_p1] = 1'b1;
    end

    assign out_valid = vld_p[ROWS +: COLS];

    // Lane 0 passes straight through; lane r sits behind r data registers.
    assign west_data[15:0] = vld_p[0] ? a_rd_data[15:0] : 16'h0000;

    for (genvar r = 1; r < ROWS; r++) begin : g_skew
        logic [15:0] dl_p [0:r-1];

        always_ff @(posedge clk) begin
            dl_p[0] <= a_rd_data[16*r +: 16];
            for (int k = 1; k < r; k++) dl_p[k] <= dl_p[k-1];
        end

        assign west_data[16*r +: 16] = vld_p[r] ? dl_p[r-1] : 16'h0000;
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
module tb_systolic_ctrl;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int M_MAX = 256;
    localparam int MW    = $clog2(M_MAX + 1);
    localparam int WAW   = $clog2(ROWS);

    logic                clk = 1'b0;
    logic                reset, start, skip_wload;
    logic [MW-1:0]       m_len;
    logic                busy, done, w_rd_en, a_rd_en;
    logic [WAW-1:0]      w_rd_addr;
    logic [ROWS-1:0]     o_load;
    logic [MW-1:0]       a_rd_addr;
    logic [ROWS*16-1:0]  a_rd_data;
    logic [ROWS*16-1:0]  west_data;
    logic [COLS-1:0]     out_valid;

    systolic_ctrl #(.ROWS(ROWS), .COLS(COLS), .M_MAX(M_MAX)) dut (
        .clk(clk), .reset(reset), .start(start), .skip_wload(skip_wload),
        .m_len(m_len), .busy(busy), .done(done), .w_rd_en(w_rd_en),
        .w_rd_addr(w_rd_addr), .o_load(o_load), .a_rd_en(a_rd_en),
        .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data), .west_data(west_data),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Activation buffer: synchronous read, garbage on the bus when not reading.
    logic [ROWS*16-1:0] amem [M_MAX];
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= amem[a_rd_addr];
        else for (int i = 0; i < ROWS; i++) a_rd_data[16*i +: 16] <= 16'($urandom);
    end

    int checks = 0;
    int errors = 0;

    // Reference model: one job record, timings derived from the job's start cycle.
    bit jv = 0;
    bit ab = 0;
    int abc, t0, jskip, jm, js, jdn;

    function automatic bit model_idle(input int n);
        return !jv || (ab && n > abc) || n > jdn;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_cycle(input int n);
        bit                 act;
        logic               e_busy, e_done, e_wen, e_aen;
        logic [WAW-1:0]     e_waddr;
        logic [ROWS-1:0]    e_oload;
        logic [MW-1:0]      e_aaddr;
        logic [ROWS*16-1:0] e_west;
        logic [COLS-1:0]    e_ov;
        logic [ROWS*16-1:0] vec;
        int t;
        e_busy = 0; e_done = 0; e_wen = 0; e_aen = 0;
        e_waddr = '0; e_oload = '0; e_aaddr = '0; e_west = '0; e_ov = '0;
        act = jv && n > t0 && n <= jdn && !(ab && n > abc);
        if (act) begin
            e_busy = 1;
            e_done = (n == jdn);
            if (!jskip) begin
                if (n >= t0 + 1 && n <= t0 + ROWS) begin
                    e_wen = 1;
                    e_waddr = WAW'(n - t0 - 1);
                end
                if (n >= t0 + 2 && n <= t0 + ROWS + 1) e_oload = ROWS'(1) << (n - t0 - 2);
            end
            if (jm > 0) begin
                if (n >= js && n < js + jm) begin
                    e_aen = 1;
                    e_aaddr = MW'(n - js);
                end
                for (int r = 0; r < ROWS; r++) begin
                    t = n - js - 1 - r;
                    if (t >= 0 && t < jm) begin
                        vec = amem[t];
                        e_west[16*r +: 16] = vec[16*r +: 16];
                    end
                end
                for (int c = 0; c < COLS; c++)
                    if (n >= js + 1 + ROWS + c && n <= js + ROWS + c + jm) e_ov[c] = 1;
            end
        end
        chk("busy", 64'(busy), 64'(e_busy));
        chk("done", 64'(done), 64'(e_done));
        chk("w_rd_en", 64'(w_rd_en), 64'(e_wen));
        chk("w_rd_addr", 64'(w_rd_addr), 64'(e_waddr));
        chk("o_load", 64'(o_load), 64'(e_oload));
        chk("a_rd_en", 64'(a_rd_en), 64'(e_aen));
        chk("a_rd_addr", 64'(a_rd_addr), 64'(e_aaddr));
        chk("west_data", 64'(west_data), 64'(e_west));
        chk("out_valid", 64'(out_valid), 64'(e_ov));
    endtask

    // One clock cycle: drive inputs, update the model, check outputs on the falling edge.
    task automatic step(input bit st, input bit sk, input int ml, input bit rs);
        int n;
        n = cyc;
        reset = rs; start = st; skip_wload = sk; m_len = MW'(ml);
        if (rs) begin
            if (jv && !ab) begin ab = 1; abc = n; end
        end else if (st && model_idle(n)) begin
            jv = 1; ab = 0; t0 = n; jskip = sk;
            jm = (ml > M_MAX) ? M_MAX : ml;
            js = sk ? t0 + 1 : t0 + ROWS + 2;
            jdn = (jm == 0) ? js : js + ROWS + COLS + jm;
        end
        @(negedge clk);
        check_cycle(n);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_steps(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0);
    endtask

    // Step until the model says the job is over; optional ignored start pulses while busy.
    task automatic run_to_done(input bit poke);
        int guard;
        guard = 0;
        while (cyc <= jdn && guard < 2000) begin
            if (poke) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15), 0);
            else      step(0, 0, 0, 0);
            guard++;
        end
        chk("job_completes_in_budget", 64'(guard < 2000), 64'(1));
    endtask

    task automatic fill_amem();
        for (int i = 0; i < M_MAX; i++)
            for (int r = 0; r < ROWS; r++) amem[i][16*r +: 16] = 16'($urandom);
    endtask

    initial begin
        reset = 1; start = 0; skip_wload = 0; m_len = '0;
        fill_amem();
        @(posedge clk);
        #1;
        step(0, 0, 0, 1);
        step(1, 0, 3, 1);
        idle_steps(2);

        // Full load then a 3-vector stream.
        step(1, 0, 3, 0);
        run_to_done(0);
        idle_steps(2);

        // bf16 1.0, 2.0, 3.0, 4.0 on lanes 0..3 for every vector, reusing weights.
        for (int i = 0; i < 3; i++) amem[i] = {16'h4080, 16'h4040, 16'h4000, 16'h3F80};
        step(1, 1, 3, 0);
        run_to_done(0);
        idle_steps(1);

        fill_amem();
        step(1, 1, 1, 0);
        run_to_done(0);
        idle_steps(1);

        // Load-only job.
        step(1, 0, 0, 0);
        run_to_done(0);
        idle_steps(1);

        // Skip with zero length: done right after start.
        step(1, 1, 0, 0);
        run_to_done(0);
        idle_steps(1);

        // Reset two cycles into STREAM, then a clean job.
        fill_amem();
        step(1, 0, 6, 0);
        for (int i = 0; i < ROWS + 3; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        idle_steps(3);
        step(1, 0, 4, 0);
        run_to_done(0);

        // Start pulses while busy are ignored; back-to-back start right after done.
        fill_amem();
        step(1, 0, 5, 0);
        run_to_done(1);
        step(1, 1, 2, 0);
        run_to_done(0);
        idle_steps(1);

        // Oversized length saturates.
        fill_amem();
        step(1, 1, 300, 0);
        run_to_done(0);
        idle_steps(2);

        // Randomized jobs.
        for (int j = 0; j < 12; j++) begin
            fill_amem();
            step(1, 1'($urandom_range(0, 1)), $urandom_range(0, 10), 0);
            run_to_done(1);
            idle_steps($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
